// File: rtl/update_knn13_pkg.sv
// Shared widths and the round-robin grant search for the update_knn13 datapath.
package update_knn13_pkg;

  localparam int A_WIDTH      = 17;
  localparam int B_WIDTH      = 15;
  localparam int P_WIDTH      = A_WIDTH + B_WIDTH;
  localparam int MUL_LATENCY  = 2;

  // Largest supported requester count and its index width.
  localparam int MAX_REQ      = 8;
  localparam int MAX_ID_WIDTH = 3;
  localparam int CAND_WIDTH   = MAX_ID_WIDTH + 1;

  typedef struct packed {
    logic                    found;
    logic [MAX_ID_WIDTH-1:0] idx;
  } rr_pick_t;

  // First asserted requester searching upward from rr, wrapping at num_req.
  // rr < num_req and i < num_req, so a single subtraction folds the wrap.
  function automatic rr_pick_t rr_next_grant(input logic [MAX_REQ-1:0]      valid,
                                             input int                      num_req,
                                             input logic [MAX_ID_WIDTH-1:0] rr);
    rr_pick_t              pick;
    logic [CAND_WIDTH-1:0] cand;
    pick.found = 1'b0;
    pick.idx   = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      cand = {1'b0, rr} + CAND_WIDTH'(i);
      if (int'(cand) >= num_req) begin
        cand = cand - CAND_WIDTH'(num_req);
      end
      if ((i < num_req) && !pick.found && valid[cand[MAX_ID_WIDTH-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = cand[MAX_ID_WIDTH-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/update_knn13_mul_core.sv
// Registered unsigned multiplier with clock-enable; MUL_LATENCY stages from
// operand capture to product. No reset: contents are qualified by the
// valid pipeline in the arbiter.
module update_knn13_mul_core
  import update_knn13_pkg::*;
#(
  parameter int A_W = A_WIDTH,
  parameter int B_W = B_WIDTH,
  parameter int LAT = MUL_LATENCY
) (
  input  logic             clk,
  input  logic             ce,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [A_W+B_W-1:0] p
);

  localparam int P_W = A_W + B_W;

  generate
    if (LAT == 1) begin : g_single
      logic [P_W-1:0] p_q;

      // Single stage: multiply straight into the product register.
      always_ff @(posedge clk) begin
        if (ce) p_q <= P_W'(a) * P_W'(b);
      end

      assign p = p_q;
    end else begin : g_multi
      logic [A_W-1:0] a_q;
      logic [B_W-1:0] b_q;
      logic [P_W-1:0] p_q [LAT-1];

      // Operand capture, then LAT-1 product stages, all frozen when ce is low.
      always_ff @(posedge clk) begin
        if (ce) begin
          a_q    <= a;
          b_q    <= b;
          p_q[0] <= P_W'(a_q) * P_W'(b_q);
          for (int i = 1; i < LAT - 1; i++) begin
            p_q[i] <= p_q[i-1];
          end
        end
      end

      assign p = p_q[LAT-2];
    end
  endgenerate

endmodule

// File: rtl/update_knn13_mul_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ
// requesters; results return in issue order tagged with the requester ID.
module update_knn13_mul_arb
  import update_knn13_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int A_W      = A_WIDTH,
  parameter int B_W      = B_WIDTH,
  parameter int P_W      = P_WIDTH,
  parameter int LAT      = MUL_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_WIDTH-1:0]    rsp_id,
  output logic [P_W-1:0]         rsp_p,
  output logic                   busy
);

  logic                adv;
  logic                transfer;
  rr_pick_t            pick;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] rr_q;
  logic [A_W-1:0]      mux_a;
  logic [B_W-1:0]      mux_b;
  logic [LAT-1:0]      vld_q;
  logic [ID_WIDTH-1:0] id_q [LAT];

  assign rsp_valid = vld_q[LAT-1];
  assign rsp_id    = id_q[LAT-1];
  assign busy      = |vld_q;
  assign adv       = !rsp_valid || rsp_ready;

  // Grant selection, one-hot ready and operand steering for this cycle.
  // Ready is held off while reset is asserted so nothing is accepted then.
  always_comb begin
    req_ready = '0;
    mux_a     = '0;
    mux_b     = '0;
    pick      = rr_next_grant(MAX_REQ'(req_valid), NUM_REQ, MAX_ID_WIDTH'(rr_q));
    grant     = ID_WIDTH'(pick.idx);
    transfer  = adv && pick.found && reset_n;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (transfer && (grant == ID_WIDTH'(i))) begin
        req_ready[i] = 1'b1;
        mux_a        = req_a[i*A_W +: A_W];
        mux_b        = req_b[i*B_W +: B_W];
      end
    end
  end

  // Round-robin pointer moves one past the winner on every transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q <= '0;
    end else if (transfer) begin
      rr_q <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
    end
  end

  // Valid/ID pipeline shadowing the multiplier; shifts in lockstep with ce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        id_q[i] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= transfer;
      id_q[0]  <= grant;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  update_knn13_mul_core #(
    .A_W (A_W),
    .B_W (B_W),
    .LAT (LAT)
  ) u_mul (
    .clk (clk),
    .ce  (adv),
    .a   (mux_a),
    .b   (mux_b),
    .p   (rsp_p)
  );

endmodule

// File: doc/update_knn13_mul_arb.md
# update_knn13_mul_arb

Round-robin arbiter and sequencer that shares one pipelined unsigned multiplier (17×15→32) among `NUM_REQ` requesters in the update_knn13 datapath. Each requester offers an operand pair with a valid/ready handshake. The block issues at most one product per cycle, carries the requester ID alongside the pipeline, and returns each result with its ID on a single response port. A stall on the response port freezes the whole pipeline through the multiplier clock-enable.

## Interface
- `NUM_REQ`, 4 — number of requesters (2..8).
- `ID_WIDTH`, 2 — width of the requester index; equals clog2(`NUM_REQ`).
- `A_WIDTH`, 17 — operand A width.
- `B_WIDTH`, 15 — operand B width.
- `P_WIDTH`, 32 — product width; equals `A_WIDTH`+`B_WIDTH`.
- `MUL_LATENCY`, 2 — register stages from operand capture to product.

- `clk`  in  1  — single clock, rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  — bit i: requester i offers an operand pair.
- `req_a`  in  `NUM_REQ`*`A_WIDTH`  — flattened A operands; requester i occupies slice i.
- `req_b`  in  `NUM_REQ`*`B_WIDTH`  — flattened B operands; requester i occupies slice i.
- `req_ready`  out  `NUM_REQ`  — one-hot or zero; bit i high means requester i is accepted this cycle.
- `rsp_valid`  out  1  — product available.
- `rsp_ready`  in  1  — consumer accepts the product.
- `rsp_id`  out  `ID_WIDTH`  — requester index of the current product.
- `rsp_p`  out  `P_WIDTH`  — unsigned product a*b.
- `busy`  out  1  — at least one issued operation is still in flight.

## Operation
- `adv = !rsp_valid || rsp_ready`. This signal drives the multiplier clock-enable and shifts the valid/ID pipeline.
- **Arbitration:** round-robin.
  - Pointer `rr` (`ID_WIDTH` bits).
  - When `adv` is high and any `req_valid` bit is set, the grant goes to the first asserted requester found searching upward from `rr`, with modulo-`NUM_REQ` wrap.
  - When `adv` is low, no grant is made.
- **Handshake:** `req_ready[g]` is driven combinationally, equal to `adv` AND grant==g. A transfer occurs when `req_valid[g]` and `req_ready[g]` are both high.
- **Requester obligations:**
  - A requester holds `req_a`/`req_b` stable while `req_valid` is high and it is not yet accepted.
  - `req_valid` may drop without being accepted. No grant is pending across cycles.
- **Pointer update:** on a transfer, `rr` ← grant+1, wrapping from `NUM_REQ`-1 to 0. Otherwise `rr` holds its value.
- **Operand mux:** the operands of the granted requester (zero when there is no grant) feed the multiplier.
- **Control pipeline:** a `MUL_LATENCY`-deep valid/ID pipeline shifts only when `adv` is high.
  - Stage 0 loads (transfer, grant).
  - `rsp_valid` and `rsp_id` are taken from the last stage.
  - `rsp_p` comes straight from the multiplier output.
- **Idle cycles:** when there is no transfer, a bubble (valid=0) enters the pipeline. The multiplier output for a bubble is ignored.
- **Busy:** `busy` is the OR of all pipeline valid bits.
- **Arithmetic:** a*b is unsigned, full precision. No truncation or overflow is possible.
- **Reset:**
  - Clears `rr`, all valid bits and all ID bits.
  - Operand and product registers are not reset.
  - Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `busy`=0.
  - `rsp_p` is don't-care while `rsp_valid`=0.
  - Asserting reset mid-operation discards every in-flight product. The first response after reset comes only from a post-reset transfer.

## Timing
- **Latency:** a transfer in cycle t yields `rsp_valid`=1 in cycle t+`MUL_LATENCY` when no stall occurs. Each stall cycle adds one cycle of latency.
- **Throughput:** one transfer per cycle when `rsp_ready` is held at 1.
- **Response stall:** while `rsp_valid`=1 and `rsp_ready`=0:
  - `rsp_valid`, `rsp_id` and `rsp_p` hold their values.
  - All `req_ready` bits are 0.
  - The pipeline is frozen.
- **Response accept:** `rsp_valid` and `rsp_ready` both high in the same cycle both consumes the output and permits a new transfer in that cycle (full-rate flow-through).
- **Combinational paths:** `req_ready` depends combinationally on `req_valid`, `rsp_ready`, `rr` and pipeline state. No output depends combinationally on `req_a` or `req_b`.
- **Ordering:** responses leave in issue order.

## Structure
- The shared package `update_knn13_pkg` holds the default widths (`A_WIDTH`, `B_WIDTH`, `P_WIDTH`, `MUL_LATENCY`) and a function that computes the round-robin next grant.
- Sub-module `update_knn13_mul_core`: the registered unsigned multiplier with ports `clk`, `ce`, `a`, `b`, `p` and latency `MUL_LATENCY`. The arbiter instantiates it once and drives `ce`=`adv`.
- The arbiter, pointer and valid/ID pipeline live in the top block.

## Test plan
- **Single request:** requester 2 offers a=1000, b=300, with `rsp_ready`=1.
  - `req_ready[2]` is high in cycle 0.
  - Cycle 2 shows `rsp_valid`=1, `rsp_id`=2, `rsp_p`=300000.
  - `busy` falls in cycle 3.
- **All requesters, fixed operands:** all 4 requesters are held valid with a=i+1, b=10.
  - Grants issue in order 0,1,2,3,0.
  - Responses carry `rsp_id` in the same order with `rsp_p`=10,20,30,40,10, one per cycle.
- **Fairness:** requesters 0 and 2 are held valid continuously. Grants alternate 0,2,0,2. Requesters 1 and 3 never receive `req_ready`.
- **Backpressure:** a 3-deep burst is issued from requester 1 with `rsp_ready`=0 for 5 cycles.
  - The first product holds stable.
  - `req_ready` stays 0 throughout.
  - After `rsp_ready` rises, the three products emerge back-to-back with no loss or duplication.
- **Maximum operands:** a=131071, b=32767 gives `rsp_p`=4294803457.
- **Reset mid-operation:** `reset_n` is pulsed low while 2 operations are in flight.
  - `rsp_valid`, `busy` and `req_ready` go 0 immediately (asynchronous).
  - After release, no stale response appears and arbitration restarts from requester 0.
